vproc_vregpack_mc: RTL and testbench
====================================

VPROC_VREGPACK_MC -- requirements
Module: vproc_vregpack_mc

Interface
REQ-001 SHALL have parameter VPORT_W, default 128, vreg write port width in bits.
REQ-002 SHALL have parameter VADDR_W, default 5, vreg address width.
REQ-003 SHALL have parameter RES_W, default 32, per-channel result width; VPORT_W SHALL be a multiple of RES_W, else $fatal at elaboration.
REQ-004 SHALL have parameter CH_CNT, default 2, number of result channels (1..8).
REQ-005 SHALL have parameter INSTR_ID_W, default 3, and INSTR_ID_CNT, default 8, for instruction ID width and count.
REQ-006 SHALL have parameter PEND_CLR_BULK, default 0; 1 means pending-write clears cover an aligned group of vregs.
REQ-007 SHALL have ports: clk_i in 1 clock; async_rst_ni in 1 reset.
REQ-008 SHALL have per-channel input ports, each CH_CNT-wide packed: pipe_in_valid_i in 1 (per channel); pipe_in_ready_o out 1; pipe_in_instr_id_i in INSTR_ID_W; pipe_in_vaddr_i in VADDR_W; pipe_in_res_valid_i in 1; pipe_in_shift_i in 1; pipe_in_store_i in 1; pipe_in_res_data_i in RES_W; pipe_in_res_mask_i in RES_W/8; pipe_in_pend_clear_i in 1; pipe_in_pend_clear_cnt_i in PCLR_W; pipe_in_instr_done_i in 1.
REQ-009 SHALL have write-port ports: vreg_wr_valid_o out 1; vreg_wr_ready_i in 1; vreg_wr_addr_o out VADDR_W; vreg_wr_be_o out VPORT_W/8; vreg_wr_data_o out VPORT_W.
REQ-010 SHALL have hazard and ID ports: pending_vreg_reads_i in 2^VADDR_W; clear_pending_vreg_writes_o out 2^VADDR_W; instr_spec_i in INSTR_ID_CNT; instr_killed_i in INSTR_ID_CNT; instr_done_valid_o out CH_CNT; instr_done_id_o out CH_CNT*INSTR_ID_W.
REQ-011 The reset SHALL be async_rst_ni, asynchronous, active-low; the clock SHALL be clk_i.

Function
REQ-012 Each channel SHALL hold one stage register (valid, id, vaddr, store, pend_clear, cnt, done, VPORT_W data buffer, VPORT_W/8 mask buffer).
REQ-013 On accept with res_valid: next buffer = {res_data, buf[VPORT_W-1:RES_W]} if shift, else upper RES_W slice replaced and lower part kept; the mask buffer SHALL follow the same rule.
REQ-014 A channel stage SHALL stall while store && (pending_vreg_reads_i[vaddr] || instr_spec_i[id]).
REQ-015 A channel stage SHALL be a write candidate when valid && store && !stall && !instr_killed_i[id].
REQ-016 When valid && store && !stall && killed, the write SHALL be dropped; the stage SHALL retire that cycle without arbitration.
REQ-017 Round-robin arbiter: the grant SHALL go to the first candidate at or after pointer rr_q; the port SHALL be driven combinationally from the granted channel; vreg_wr_valid_o SHALL be 1 iff any candidate exists.
REQ-018 rr_q SHALL advance to grant+1 (mod CH_CNT) only on vreg_wr_valid_o && vreg_wr_ready_i.
REQ-019 pipe_in_ready_o[c] SHALL be 1 when: !valid[c], or (!store && !stall), or killed retire, or (granted && vreg_wr_ready_i); the handshake is zero-latency, with the input captured at the same edge.
REQ-020 The write port SHALL be stable while vreg_wr_valid_o && !vreg_wr_ready_i unless a hazard or kill input changes.
REQ-021 instr_done_valid_o[c] SHALL be valid[c] && done[c] && stage retiring this cycle; instr_done_id_o[c] SHALL be id[c].
REQ-022 Pending clear: each retiring stage with pend_clear SHALL contribute a mask; contributions SHALL be ORed and registered; clear_pending_vreg_writes_o appears 1 cycle after retire.
REQ-023 With PEND_CLR_BULK=0 the mask SHALL be the one-hot bit at vaddr; with 1, it SHALL cover all i with (i & (~0<<cnt)) == (vaddr & (~0<<cnt)).
REQ-024 Simultaneous clears from several channels in one cycle SHALL all be reflected in the same output cycle.

Reset
REQ-025 On async_rst_ni low: all stage valids 0, rr_q 0, clear_pending_vreg_writes_o 0, vreg_wr_valid_o 0, instr_done_valid_o 0, pipe_in_ready_o all 1.
REQ-026 Reset mid-operation SHALL discard buffered data with no write and no clear; data and mask buffers SHALL be non-reset flops.

Structure
REQ-027 PCLR_W = $clog2(VADDR_W-1) and the round-robin helper function SHALL live in vproc_pkg.
REQ-028 Per-channel packing SHALL be one sub-module vproc_vregpack_ch, instantiated CH_CNT times; arbitration and clear logic SHALL be in the top.

Verification
REQ-029 Scenario: CH_CNT=2, ch0 writes four RES_W=32 shifted results 0x11..0x44, store on the 4th, ready=1 -> write data 0x44332211 in the top-down order, be 0xFFFF, vaddr 3, one cycle.
REQ-030 Scenario: both channels present a store in the same cycle, rr_q=0 -> ch0 is granted, ch1 is granted the next cycle, and rr_q returns to 0.
REQ-031 Scenario: vreg_wr_ready_i=0 for 3 cycles -> the port is held stable and pipe_in_ready_o[granted]=0 until ready.
REQ-032 Scenario: instr_killed_i[id]=1 on a store stage -> no vreg_wr_valid_o, instr_done fires, and the clear still fires for vaddr.
REQ-033 Scenario: PEND_CLR_BULK=1, vaddr=6, cnt=2 -> clear bits 4..7 the cycle after retire; pending_vreg_reads_i[6]=1 first -> stall until it drops.
REQ-034 Scenario: async reset asserted during a stall -> outputs match REQ-025 immediately, and no write occurs after release.

Source files
------------

// File: rtl/vproc_pkg.sv
// Shared constants and helpers for the vector register write-back packer.
package vproc_pkg;

    localparam int unsigned VADDR_W_DEFAULT = 5;
    localparam int unsigned RR_MAX_CH       = 8;

    // Width of the pending-clear group count; $clog2(vaddr_w-1), never below 1.
    function automatic int unsigned pclr_width(input int unsigned vaddr_w);
        return (vaddr_w > 2) ? $clog2(vaddr_w - 1) : 1;
    endfunction

    localparam int unsigned PCLR_W = pclr_width(VADDR_W_DEFAULT);

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of cand at or after ptr, wrapping at ch_cnt.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] cand,
                                         input logic [2:0]           ptr,
                                         input int unsigned          ch_cnt);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 0; k < RR_MAX_CH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= ch_cnt) begin
                idx = idx - ch_cnt;
            end
            if ((k < ch_cnt) && !res.found && cand[idx[2:0]]) begin
                res.found = 1'b1;
                res.idx   = 3'(idx);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vproc_vregpack_ch.sv
// One result channel: accumulates results into a port-wide buffer and holds a
// single stage until its store is written, dropped, or it passes through.
module vproc_vregpack_ch
    import vproc_pkg::*;
#(
    parameter int unsigned VPORT_W      = 128,
    parameter int unsigned VADDR_W      = 5,
    parameter int unsigned RES_W        = 32,
    parameter int unsigned INSTR_ID_W   = 3,
    parameter int unsigned INSTR_ID_CNT = 8,
    parameter int unsigned PCLR_CNT_W   = 2
) (
    input  logic                    clk_i,
    input  logic                    async_rst_ni,
    input  logic                    i_valid,
    input  logic [INSTR_ID_W-1:0]   i_instr_id,
    input  logic [VADDR_W-1:0]      i_vaddr,
    input  logic                    i_res_valid,
    input  logic                    i_shift,
    input  logic                    i_store,
    input  logic [RES_W-1:0]        i_res_data,
    input  logic [RES_W/8-1:0]      i_res_mask,
    input  logic                    i_pend_clear,
    input  logic [PCLR_CNT_W-1:0]   i_pend_clear_cnt,
    input  logic                    i_instr_done,
    input  logic [2**VADDR_W-1:0]   i_pending_reads,
    input  logic [INSTR_ID_CNT-1:0] i_instr_spec,
    input  logic [INSTR_ID_CNT-1:0] i_instr_killed,
    input  logic                    i_wr_accept,
    output logic                    o_ready_c,
    output logic                    o_cand_c,
    output logic                    o_retire_c,
    output logic                    o_done_valid_c,
    output logic [INSTR_ID_W-1:0]   o_id,
    output logic [VADDR_W-1:0]      o_vaddr,
    output logic                    o_pend_clear,
    output logic [PCLR_CNT_W-1:0]   o_cnt,
    output logic [VPORT_W-1:0]      o_data,
    output logic [VPORT_W/8-1:0]    o_mask
);

    localparam int unsigned MASK_W = RES_W / 8;
    localparam int unsigned BE_W   = VPORT_W / 8;

    logic                  r_valid;
    logic [INSTR_ID_W-1:0] r_id;
    logic [VADDR_W-1:0]    r_vaddr;
    logic                  r_store;
    logic                  r_pend_clear;
    logic [PCLR_CNT_W-1:0] r_cnt;
    logic                  r_done;
    logic [VPORT_W-1:0]    r_buf;
    logic [BE_W-1:0]       r_msk;

    logic                  w_stall;
    logic                  w_killed;
    logic                  w_kill_retire;
    logic [VPORT_W-1:0]    w_buf_nxt;
    logic [BE_W-1:0]       w_msk_nxt;

    assign w_stall       = r_store && (i_pending_reads[r_vaddr] || i_instr_spec[r_id]);
    assign w_killed      = i_instr_killed[r_id];
    assign o_cand_c      = r_valid && r_store && !w_stall && !w_killed;
    assign w_kill_retire = r_valid && r_store && !w_stall && w_killed;
    assign o_ready_c     = !r_valid || (!r_store && !w_stall) || w_kill_retire || i_wr_accept;
    assign o_retire_c    = r_valid && o_ready_c;
    assign o_done_valid_c = o_retire_c && r_done;

    // New result enters at the top; shift moves the rest down, otherwise the top slice is replaced.
    if (VPORT_W == RES_W) begin : g_single
        assign w_buf_nxt = i_res_data;
        assign w_msk_nxt = i_res_mask;
    end else begin : g_multi
        assign w_buf_nxt = i_shift ? {i_res_data, r_buf[VPORT_W-1:RES_W]}
                                   : {i_res_data, r_buf[VPORT_W-RES_W-1:0]};
        assign w_msk_nxt = i_shift ? {i_res_mask, r_msk[BE_W-1:MASK_W]}
                                   : {i_res_mask, r_msk[BE_W-MASK_W-1:0]};
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_valid      <= 1'b0;
            r_id         <= '0;
            r_vaddr      <= '0;
            r_store      <= 1'b0;
            r_pend_clear <= 1'b0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
        end else if (o_ready_c) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_id         <= i_instr_id;
                r_vaddr      <= i_vaddr;
                r_store      <= i_store;
                r_pend_clear <= i_pend_clear;
                r_cnt        <= i_pend_clear_cnt;
                r_done       <= i_instr_done;
            end
        end
    end

    // Data path buffers carry no reset.
    always_ff @(posedge clk_i) begin
        if (o_ready_c && i_valid && i_res_valid) begin
            r_buf <= w_buf_nxt;
            r_msk <= w_msk_nxt;
        end
    end

    assign o_id         = r_id;
    assign o_vaddr      = r_vaddr;
    assign o_pend_clear = r_pend_clear;
    assign o_cnt        = r_cnt;
    assign o_data       = r_buf;
    assign o_mask       = r_msk;

endmodule

// File: rtl/vproc_vregpack_mc.sv
// Multi-channel vreg write-back packer: per-channel staging, round-robin
// arbitration onto a single vreg write port, and pending-write clear generation.
module vproc_vregpack_mc
    import vproc_pkg::*;
#(
    parameter int unsigned VPORT_W       = 128,
    parameter int unsigned VADDR_W       = 5,
    parameter int unsigned RES_W         = 32,
    parameter int unsigned CH_CNT        = 2,
    parameter int unsigned INSTR_ID_W    = 3,
    parameter int unsigned INSTR_ID_CNT  = 8,
    parameter bit          PEND_CLR_BULK = 1'b0
) (
    input  logic                                      clk_i,
    input  logic                                      async_rst_ni,
    input  logic [CH_CNT-1:0]                         pipe_in_valid_i,
    output logic [CH_CNT-1:0]                         pipe_in_ready_o,
    input  logic [CH_CNT*INSTR_ID_W-1:0]              pipe_in_instr_id_i,
    input  logic [CH_CNT*VADDR_W-1:0]                 pipe_in_vaddr_i,
    input  logic [CH_CNT-1:0]                         pipe_in_res_valid_i,
    input  logic [CH_CNT-1:0]                         pipe_in_shift_i,
    input  logic [CH_CNT-1:0]                         pipe_in_store_i,
    input  logic [CH_CNT*RES_W-1:0]                   pipe_in_res_data_i,
    input  logic [CH_CNT*(RES_W/8)-1:0]               pipe_in_res_mask_i,
    input  logic [CH_CNT-1:0]                         pipe_in_pend_clear_i,
    input  logic [CH_CNT*pclr_width(VADDR_W)-1:0]     pipe_in_pend_clear_cnt_i,
    input  logic [CH_CNT-1:0]                         pipe_in_instr_done_i,
    output logic                                      vreg_wr_valid_o,
    input  logic                                      vreg_wr_ready_i,
    output logic [VADDR_W-1:0]                        vreg_wr_addr_o,
    output logic [VPORT_W/8-1:0]                      vreg_wr_be_o,
    output logic [VPORT_W-1:0]                        vreg_wr_data_o,
    input  logic [2**VADDR_W-1:0]                     pending_vreg_reads_i,
    output logic [2**VADDR_W-1:0]                     clear_pending_vreg_writes_o,
    input  logic [INSTR_ID_CNT-1:0]                   instr_spec_i,
    input  logic [INSTR_ID_CNT-1:0]                   instr_killed_i,
    output logic [CH_CNT-1:0]                         instr_done_valid_o,
    output logic [CH_CNT*INSTR_ID_W-1:0]              instr_done_id_o
);

    localparam int unsigned PCLR_L = pclr_width(VADDR_W);
    localparam int unsigned MASK_W = RES_W / 8;
    localparam int unsigned BE_W   = VPORT_W / 8;
    localparam int unsigned NREG   = 2 ** VADDR_W;
    localparam int unsigned RR_W   = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;

    if ((VPORT_W % RES_W) != 0) begin : g_bad_width
        $fatal(1, "vproc_vregpack_mc: VPORT_W must be a multiple of RES_W");
    end
    if ((CH_CNT < 1) || (CH_CNT > RR_MAX_CH)) begin : g_bad_ch_cnt
        $fatal(1, "vproc_vregpack_mc: CH_CNT must be within 1..8");
    end

    logic [CH_CNT-1:0]     w_cand;
    logic [CH_CNT-1:0]     w_retire;
    logic [CH_CNT-1:0]     w_pclr;
    logic [CH_CNT-1:0]     w_gnt;
    logic [INSTR_ID_W-1:0] w_id    [CH_CNT];
    logic [VADDR_W-1:0]    w_vaddr [CH_CNT];
    logic [VADDR_W-1:0]    w_grp   [CH_CNT];
    logic [PCLR_L-1:0]     w_cnt   [CH_CNT];
    logic [VPORT_W-1:0]    w_data  [CH_CNT];
    logic [BE_W-1:0]       w_mask  [CH_CNT];

    rr_pick_t              w_pick;
    logic [RR_W-1:0]       w_rr_nxt;
    logic [NREG-1:0]       w_clr_nxt;
    logic [RR_W-1:0]       r_rr;
    logic [NREG-1:0]       r_clr;

    for (genvar c = 0; c < CH_CNT; c++) begin : g_ch
        vproc_vregpack_ch #(
            .VPORT_W      (VPORT_W),
            .VADDR_W      (VADDR_W),
            .RES_W        (RES_W),
            .INSTR_ID_W   (INSTR_ID_W),
            .INSTR_ID_CNT (INSTR_ID_CNT),
            .PCLR_CNT_W   (PCLR_L)
        ) u_ch (
            .clk_i            (clk_i),
            .async_rst_ni     (async_rst_ni),
            .i_valid          (pipe_in_valid_i[c]),
            .i_instr_id       (pipe_in_instr_id_i[c*INSTR_ID_W +: INSTR_ID_W]),
            .i_vaddr          (pipe_in_vaddr_i[c*VADDR_W +: VADDR_W]),
            .i_res_valid      (pipe_in_res_valid_i[c]),
            .i_shift          (pipe_in_shift_i[c]),
            .i_store          (pipe_in_store_i[c]),
            .i_res_data       (pipe_in_res_data_i[c*RES_W +: RES_W]),
            .i_res_mask       (pipe_in_res_mask_i[c*MASK_W +: MASK_W]),
            .i_pend_clear     (pipe_in_pend_clear_i[c]),
            .i_pend_clear_cnt (pipe_in_pend_clear_cnt_i[c*PCLR_L +: PCLR_L]),
            .i_instr_done     (pipe_in_instr_done_i[c]),
            .i_pending_reads  (pending_vreg_reads_i),
            .i_instr_spec     (instr_spec_i),
            .i_instr_killed   (instr_killed_i),
            .i_wr_accept      (w_gnt[c] && vreg_wr_ready_i),
            .o_ready_c        (pipe_in_ready_o[c]),
            .o_cand_c         (w_cand[c]),
            .o_retire_c       (w_retire[c]),
            .o_done_valid_c   (instr_done_valid_o[c]),
            .o_id             (w_id[c]),
            .o_vaddr          (w_vaddr[c]),
            .o_pend_clear     (w_pclr[c]),
            .o_cnt            (w_cnt[c]),
            .o_data           (w_data[c]),
            .o_mask           (w_mask[c])
        );

        assign instr_done_id_o[c*INSTR_ID_W +: INSTR_ID_W] = w_id[c];
        // Bulk clears ignore the low cnt address bits; otherwise exact match.
        assign w_grp[c] = PEND_CLR_BULK ? ({VADDR_W{1'b1}} << w_cnt[c]) : {VADDR_W{1'b1}};
    end

    assign w_pick          = rr_pick(RR_MAX_CH'(w_cand), 3'(r_rr), CH_CNT);
    assign vreg_wr_valid_o = w_pick.found;
    assign w_rr_nxt        = ((32'(w_pick.idx) + 32'd1) >= CH_CNT) ? '0
                                                                   : RR_W'(32'(w_pick.idx) + 32'd1);

    // Write port is a pure mux of the granted stage.
    always_comb begin
        w_gnt          = '0;
        vreg_wr_addr_o = '0;
        vreg_wr_be_o   = '0;
        vreg_wr_data_o = '0;
        for (int unsigned c = 0; c < CH_CNT; c++) begin
            if (w_pick.found && (w_pick.idx == 3'(c))) begin
                w_gnt[c]       = 1'b1;
                vreg_wr_addr_o = w_vaddr[c];
                vreg_wr_be_o   = w_mask[c];
                vreg_wr_data_o = w_data[c];
            end
        end
    end

    always_comb begin
        w_clr_nxt = '0;
        for (int unsigned c = 0; c < CH_CNT; c++) begin
            if (w_retire[c] && w_pclr[c]) begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    if ((VADDR_W'(i) & w_grp[c]) == (w_vaddr[c] & w_grp[c])) begin
                        w_clr_nxt[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_rr  <= '0;
            r_clr <= '0;
        end else begin
            r_clr <= w_clr_nxt;
            if (vreg_wr_valid_o && vreg_wr_ready_i) begin
                r_rr <= w_rr_nxt;
            end
        end
    end

    assign clear_pending_vreg_writes_o = r_clr;

endmodule

// File: tb/tb_vproc_vregpack_mc.sv
// Directed bench for vproc_vregpack_mc: packing, arbitration, back-pressure,
// kill, bulk pending clears and asynchronous reset.
module tb_vproc_vregpack_mc;

    localparam int unsigned CH  = 2;
    localparam int unsigned IDW = 3;
    localparam int unsigned VAW = 5;
    localparam int unsigned RW  = 32;
    localparam int unsigned VPW = 128;
    localparam int unsigned PW  = 2;

    logic                 clk_i = 1'b0;
    logic                 async_rst_ni;
    logic [CH-1:0]        pipe_in_valid_i;
    logic [CH-1:0]        pipe_in_ready_o;
    logic [CH*IDW-1:0]    pipe_in_instr_id_i;
    logic [CH*VAW-1:0]    pipe_in_vaddr_i;
    logic [CH-1:0]        pipe_in_res_valid_i;
    logic [CH-1:0]        pipe_in_shift_i;
    logic [CH-1:0]        pipe_in_store_i;
    logic [CH*RW-1:0]     pipe_in_res_data_i;
    logic [CH*(RW/8)-1:0] pipe_in_res_mask_i;
    logic [CH-1:0]        pipe_in_pend_clear_i;
    logic [CH*PW-1:0]     pipe_in_pend_clear_cnt_i;
    logic [CH-1:0]        pipe_in_instr_done_i;
    logic                 vreg_wr_valid_o;
    logic                 vreg_wr_ready_i;
    logic [VAW-1:0]       vreg_wr_addr_o;
    logic [VPW/8-1:0]     vreg_wr_be_o;
    logic [VPW-1:0]       vreg_wr_data_o;
    logic [31:0]          pending_vreg_reads_i;
    logic [31:0]          clear_pending_vreg_writes_o;
    logic [7:0]           instr_spec_i;
    logic [7:0]           instr_killed_i;
    logic [CH-1:0]        instr_done_valid_o;
    logic [CH*IDW-1:0]    instr_done_id_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    vproc_vregpack_mc #(
        .VPORT_W       (VPW),
        .VADDR_W       (VAW),
        .RES_W         (RW),
        .CH_CNT        (CH),
        .INSTR_ID_W    (IDW),
        .INSTR_ID_CNT  (8),
        .PEND_CLR_BULK (1'b1)
    ) dut (
        .clk_i                       (clk_i),
        .async_rst_ni                (async_rst_ni),
        .pipe_in_valid_i             (pipe_in_valid_i),
        .pipe_in_ready_o             (pipe_in_ready_o),
        .pipe_in_instr_id_i          (pipe_in_instr_id_i),
        .pipe_in_vaddr_i             (pipe_in_vaddr_i),
        .pipe_in_res_valid_i         (pipe_in_res_valid_i),
        .pipe_in_shift_i             (pipe_in_shift_i),
        .pipe_in_store_i             (pipe_in_store_i),
        .pipe_in_res_data_i          (pipe_in_res_data_i),
        .pipe_in_res_mask_i          (pipe_in_res_mask_i),
        .pipe_in_pend_clear_i        (pipe_in_pend_clear_i),
        .pipe_in_pend_clear_cnt_i    (pipe_in_pend_clear_cnt_i),
        .pipe_in_instr_done_i        (pipe_in_instr_done_i),
        .vreg_wr_valid_o             (vreg_wr_valid_o),
        .vreg_wr_ready_i             (vreg_wr_ready_i),
        .vreg_wr_addr_o              (vreg_wr_addr_o),
        .vreg_wr_be_o                (vreg_wr_be_o),
        .vreg_wr_data_o              (vreg_wr_data_o),
        .pending_vreg_reads_i        (pending_vreg_reads_i),
        .clear_pending_vreg_writes_o (clear_pending_vreg_writes_o),
        .instr_spec_i                (instr_spec_i),
        .instr_killed_i              (instr_killed_i),
        .instr_done_valid_o          (instr_done_valid_o),
        .instr_done_id_o             (instr_done_id_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [IDW-1:0] id, input logic [VAW-1:0] va,
                          input logic shift, input logic store, input logic [RW-1:0] d,
                          input logic pclr, input logic [PW-1:0] cnt, input logic done);
        pipe_in_valid_i[c]                  = 1'b1;
        pipe_in_res_valid_i[c]              = 1'b1;
        pipe_in_instr_id_i[c*IDW +: IDW]    = id;
        pipe_in_vaddr_i[c*VAW +: VAW]       = va;
        pipe_in_shift_i[c]                  = shift;
        pipe_in_store_i[c]                  = store;
        pipe_in_res_data_i[c*RW +: RW]      = d;
        pipe_in_res_mask_i[c*4 +: 4]        = 4'hF;
        pipe_in_pend_clear_i[c]             = pclr;
        pipe_in_pend_clear_cnt_i[c*PW +: PW] = cnt;
        pipe_in_instr_done_i[c]             = done;
    endtask

    task automatic idle_ch(input int c);
        pipe_in_valid_i[c]     = 1'b0;
        pipe_in_res_valid_i[c] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        async_rst_ni             = 1'b0;
        vreg_wr_ready_i          = 1'b1;
        pending_vreg_reads_i     = '0;
        instr_spec_i             = '0;
        instr_killed_i           = '0;
        pipe_in_valid_i          = '0;
        pipe_in_instr_id_i       = '0;
        pipe_in_vaddr_i          = '0;
        pipe_in_res_valid_i      = '0;
        pipe_in_shift_i          = '0;
        pipe_in_store_i          = '0;
        pipe_in_res_data_i       = '0;
        pipe_in_res_mask_i       = '0;
        pipe_in_pend_clear_i     = '0;
        pipe_in_pend_clear_cnt_i = '0;
        pipe_in_instr_done_i     = '0;
        #2;
        chk("rst_wr_valid", 128'(vreg_wr_valid_o), 128'(0));
        chk("rst_ready", 128'(pipe_in_ready_o), 128'(2'b11));
        chk("rst_clear", 128'(clear_pending_vreg_writes_o), 128'(0));
        chk("rst_done", 128'(instr_done_valid_o), 128'(0));
        repeat (2) @(posedge clk_i);
        #3 async_rst_ni = 1'b1;
        step();

        // Four shifted results on ch0, store on the last
        set_ch(0, 3'd1, 5'd3, 1'b1, 1'b0, 32'h11, 1'b0, 2'd0, 1'b0);
        #1 chk("s1_ready_empty", 128'(pipe_in_ready_o[0]), 128'(1));
        step();
        set_ch(0, 3'd1, 5'd3, 1'b1, 1'b0, 32'h22, 1'b0, 2'd0, 1'b0);
        step();
        set_ch(0, 3'd1, 5'd3, 1'b1, 1'b0, 32'h33, 1'b0, 2'd0, 1'b0);
        step();
        set_ch(0, 3'd1, 5'd3, 1'b1, 1'b1, 32'h44, 1'b1, 2'd0, 1'b1);
        step();
        idle_ch(0);
        #1;
        chk("s1_wr_valid", 128'(vreg_wr_valid_o), 128'(1));
        chk("s1_addr", 128'(vreg_wr_addr_o), 128'(5'd3));
        chk("s1_be", 128'(vreg_wr_be_o), 128'(16'hFFFF));
        chk("s1_data", vreg_wr_data_o, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("s1_done_v", 128'(instr_done_valid_o), 128'(2'b01));
        chk("s1_done_id", 128'(instr_done_id_o[2:0]), 128'(3'd1));
        chk("s1_ready", 128'(pipe_in_ready_o), 128'(2'b11));
        step();
        chk("s1_wr_once", 128'(vreg_wr_valid_o), 128'(0));
        chk("s1_clear", 128'(clear_pending_vreg_writes_o), 128'(32'h0000_0008));
        chk("s1_done_off", 128'(instr_done_valid_o), 128'(0));
        step();
        chk("s1_clear_off", 128'(clear_pending_vreg_writes_o), 128'(0));

        // ch1 alone, non-shift store: moves the pointer back to ch0
        set_ch(1, 3'd2, 5'd7, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 2'd0, 1'b1);
        step();
        idle_ch(1);
        #1;
        chk("c1_addr", 128'(vreg_wr_addr_o), 128'(5'd7));
        chk("c1_data_top", 128'(vreg_wr_data_o[127:96]), 128'(32'hA5A5A5A5));
        chk("c1_be_top", 128'(vreg_wr_be_o[15:12]), 128'(4'hF));
        chk("c1_done_v", 128'(instr_done_valid_o), 128'(2'b10));
        chk("c1_done_id", 128'(instr_done_id_o[5:3]), 128'(3'd2));
        step();

        // Both channels store in the same cycle
        set_ch(0, 3'd3, 5'd4, 1'b1, 1'b1, 32'hB0, 1'b0, 2'd0, 1'b1);
        set_ch(1, 3'd4, 5'd5, 1'b1, 1'b1, 32'hC1, 1'b0, 2'd0, 1'b1);
        step();
        idle_ch(0);
        idle_ch(1);
        #1;
        chk("s2_first_addr", 128'(vreg_wr_addr_o), 128'(5'd4));
        chk("s2_first_data", vreg_wr_data_o, {32'hB0, 32'h44, 32'h33, 32'h22});
        chk("s2_first_ready", 128'(pipe_in_ready_o), 128'(2'b01));
        chk("s2_first_done", 128'(instr_done_valid_o), 128'(2'b01));
        step();
        chk("s2_second_addr", 128'(vreg_wr_addr_o), 128'(5'd5));
        chk("s2_second_data", 128'(vreg_wr_data_o[127:64]), 128'({32'hC1, 32'hA5A5A5A5}));
        chk("s2_second_ready", 128'(pipe_in_ready_o), 128'(2'b11));
        chk("s2_second_id", 128'(instr_done_id_o[5:3]), 128'(3'd4));
        step();
        chk("s2_idle", 128'(vreg_wr_valid_o), 128'(0));

        // Back-pressure: port holds for three cycles
        set_ch(0, 3'd3, 5'd8, 1'b0, 1'b1, 32'hD0, 1'b0, 2'd0, 1'b0);
        set_ch(1, 3'd4, 5'd9, 1'b1, 1'b1, 32'hE1, 1'b0, 2'd0, 1'b0);
        vreg_wr_ready_i = 1'b0;
        step();
        idle_ch(0);
        idle_ch(1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("s3_hold_valid", 128'(vreg_wr_valid_o), 128'(1));
            chk("s3_hold_addr", 128'(vreg_wr_addr_o), 128'(5'd8));
            chk("s3_hold_data", vreg_wr_data_o, {32'hD0, 32'h44, 32'h33, 32'h22});
            chk("s3_hold_ready", 128'(pipe_in_ready_o), 128'(2'b00));
            step();
        end
        vreg_wr_ready_i = 1'b1;
        #1;
        chk("s3_rel_addr", 128'(vreg_wr_addr_o), 128'(5'd8));
        chk("s3_rel_ready", 128'(pipe_in_ready_o), 128'(2'b01));
        step();
        chk("s3_ch1_addr", 128'(vreg_wr_addr_o), 128'(5'd9));
        chk("s3_ch1_data", 128'(vreg_wr_data_o[127:64]), 128'({32'hE1, 32'hC1}));
        chk("s3_ch1_ready", 128'(pipe_in_ready_o), 128'(2'b11));
        step();
        chk("s3_idle", 128'(vreg_wr_valid_o), 128'(0));

        // Killed store: dropped, done and clear still fire
        instr_killed_i[5] = 1'b1;
        set_ch(0, 3'd5, 5'd10, 1'b1, 1'b1, 32'h77, 1'b1, 2'd0, 1'b1);
        step();
        idle_ch(0);
        #1;
        chk("s4_no_write", 128'(vreg_wr_valid_o), 128'(0));
        chk("s4_done_v", 128'(instr_done_valid_o), 128'(2'b01));
        chk("s4_done_id", 128'(instr_done_id_o[2:0]), 128'(3'd5));
        chk("s4_ready", 128'(pipe_in_ready_o[0]), 128'(1));
        step();
        instr_killed_i[5] = 1'b0;
        #1;
        chk("s4_clear", 128'(clear_pending_vreg_writes_o), 128'(32'h0000_0400));
        chk("s4_no_write_after", 128'(vreg_wr_valid_o), 128'(0));

        // Bulk clear of an aligned group of 4, after a read-hazard stall
        pending_vreg_reads_i[6] = 1'b1;
        set_ch(1, 3'd6, 5'd6, 1'b1, 1'b1, 32'h66, 1'b1, 2'd2, 1'b1);
        step();
        idle_ch(1);
        #1;
        chk("s5_stall_valid", 128'(vreg_wr_valid_o), 128'(0));
        chk("s5_stall_ready", 128'(pipe_in_ready_o[1]), 128'(0));
        chk("s5_stall_done", 128'(instr_done_valid_o), 128'(0));
        step();
        chk("s5_stall2_valid", 128'(vreg_wr_valid_o), 128'(0));
        chk("s5_stall2_clear", 128'(clear_pending_vreg_writes_o), 128'(0));
        pending_vreg_reads_i[6] = 1'b0;
        #1;
        chk("s5_go_valid", 128'(vreg_wr_valid_o), 128'(1));
        chk("s5_go_addr", 128'(vreg_wr_addr_o), 128'(5'd6));
        chk("s5_go_ready", 128'(pipe_in_ready_o[1]), 128'(1));
        chk("s5_go_done_id", 128'(instr_done_id_o[5:3]), 128'(3'd6));
        step();
        chk("s5_bulk_clear", 128'(clear_pending_vreg_writes_o), 128'(32'h0000_00F0));
        chk("s5_after", 128'(vreg_wr_valid_o), 128'(0));

        // Asynchronous reset during a stall
        pending_vreg_reads_i[12] = 1'b1;
        set_ch(0, 3'd7, 5'd12, 1'b1, 1'b1, 32'h12, 1'b1, 2'd0, 1'b1);
        step();
        idle_ch(0);
        #1;
        chk("s6_stalled", 128'(pipe_in_ready_o[0]), 128'(0));
        #1 async_rst_ni = 1'b0;
        #1;
        chk("s6_rst_ready", 128'(pipe_in_ready_o), 128'(2'b11));
        chk("s6_rst_valid", 128'(vreg_wr_valid_o), 128'(0));
        chk("s6_rst_done", 128'(instr_done_valid_o), 128'(0));
        chk("s6_rst_clear", 128'(clear_pending_vreg_writes_o), 128'(0));
        step();
        step();
        #2;
        async_rst_ni = 1'b1;
        pending_vreg_reads_i[12] = 1'b0;
        #1;
        chk("s6_rel_valid", 128'(vreg_wr_valid_o), 128'(0));
        chk("s6_rel_ready", 128'(pipe_in_ready_o), 128'(2'b11));
        step();
        chk("s6_post_valid", 128'(vreg_wr_valid_o), 128'(0));
        chk("s6_post_clear", 128'(clear_pending_vreg_writes_o), 128'(0));
        chk("s6_post_done", 128'(instr_done_valid_o), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
